seq_feed_ctrl: RTL and testbench
================================

Name: seq_feed_ctrl

Overview:
- Controller that sequences the 101011 sequence-detector datapath.
- Captures a WORD_W-bit test pattern from the board switches and feeds it MSB-first, one bit per step, into the detector. Each step is either a manual step pulse or an auto-step prescaler tick.
- Counts detector hits and reports progress, done and overflow to LEDs/display.
- Sits between the debounced button pulses and the detector instance in the top level.

Parameters:
- WORD_W, 16, pattern length in bits (2..32).
- IDX_W, 4, width of bit_idx; must satisfy 2^IDX_W >= WORD_W.
- CNT_W, 4, width of the hit counter.
- PRESCALE, 50_000_000, clocks per auto step (>=2).

Ports:
- System_clk  in  1  system clock; all logic on rising edge.
- System_rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle synchronous pulse (already debounced): capture pattern_in.
- start  in  1  one-cycle pulse: begin a feed run.
- step_req  in  1  one-cycle pulse: manual step; used only when auto_en=0.
- auto_en  in  1  level: 1 = prescaler-driven stepping.
- pattern_in  in  WORD_W  switch pattern.
- det_hit  in  1  detector match flag, registered by the detector on det_step.
- det_bit  out  WORD_W->1  serial bit presented to the detector.
- det_step  out  1  one-cycle step strobe (detector clock enable).
- det_clr  out  1  one-cycle detector clear.
- busy  out  1  high in CLEAR/FEED/STEP/CHECK.
- done  out  1  high in DONE.
- bit_idx  out  IDX_W  index of the next bit to feed.
- hit_cnt  out  CNT_W  saturating hit count.
- hit_ovf  out  1  sticky; set on an attempted increment past all-ones.

Behaviour:
- Reset (async, System_rst_n=0):
  - State IDLE.
  - All outputs 0; pattern register 0; prescaler 0.
  - Reset asserted mid-run aborts immediately; there is no resume.
- All outputs are registered.
- FSM states: IDLE, LOADED, CLEAR, FEED, STEP, CHECK, DONE.
- IDLE:
  - load -> capture pattern_in, go to LOADED.
  - start is ignored.
- LOADED:
  - load -> recapture, stay in LOADED.
  - start -> CLEAR.
  - load and start in the same cycle: load wins, start is dropped.
- CLEAR (1 cycle):
  - det_clr=1; hit_cnt<=0; hit_ovf<=0; bit_idx<=0; prescaler<=0.
  - -> FEED.
- FEED (waits for a step event):
  - auto_en=0: the event is step_req.
  - auto_en=1: the event is prescaler==PRESCALE-1; the prescaler increments only in FEED and is cleared on every exit from FEED. step_req is ignored.
  - auto_en toggled mid-FEED takes effect the next cycle; the prescaler restarts from 0 when auto_en goes 0->1.
  - On the event: det_bit<=pattern[WORD_W-1-bit_idx]; det_step<=1; -> STEP.
- STEP (1 cycle):
  - det_step=1; the detector latches det_bit at the end of this cycle.
  - det_step<=0; -> CHECK.
- CHECK (1 cycle):
  - Sample det_hit. If 1: hit_cnt+1 when not all-ones, else hold and set hit_ovf.
  - If bit_idx==WORD_W-1 -> DONE (bit_idx holds).
  - Else bit_idx+1 -> FEED.
- Step latency: event at edge k -> det_step high k..k+1 -> det_hit sampled at edge k+2 -> hit_cnt visible after k+2. Minimum 3 cycles per bit.
- During CLEAR/FEED/STEP/CHECK: load and start are ignored (no abort path except reset).
- DONE:
  - done=1; hit_cnt and hit_ovf held.
  - start -> CLEAR (rerun same pattern).
  - load -> capture, go to LOADED, done<=0.
  - load and start in the same cycle: load wins.
- det_bit holds its last value between steps.
- pattern_in changes after load have no effect until the next load.

Decomposition:
- Shared package: state encoding constants (IDLE..DONE, 3 bits) and the default PRESCALE constant for the 50 MHz board clock.
- One sub-module is natural: step_prescaler (counter with enable/clear, tick output).
- Debounce stays external.

Test Plan:
- Reset mid-FEED (auto_en=0, bit_idx=7): assert System_rst_n=0 -> all outputs 0 asynchronously; state IDLE after release.
- Manual run: load 16'hAD60, start, then 16 step_req pulses spaced >=4 cycles, against the bench's behavioural overlapping 101011 detector model:
  - exactly one det_clr pulse;
  - 16 det_step pulses, bits 1,0,1,0,1,1,0,1,0,1,1,0,0,0,0,0;
  - hits after bit_idx 5 and 10; final hit_cnt=2; done=1; busy=0.
- Auto mode, PRESCALE=4, pattern 16'hFFFF, always-hit stub: det_step every 6 cycles (4 FEED + STEP + CHECK); hit_cnt saturates at 15; hit_ovf=1 after the 16th hit.
- Ignored inputs: step_req pulses while auto_en=1, and load/start pulses during FEED/STEP/CHECK -> no extra det_step; pattern unchanged; bit_idx sequence unchanged.
- Simultaneous load+start in LOADED and in DONE -> new pattern captured; state LOADED; no det_clr.
- Rerun from DONE via start -> det_clr pulse; hit_cnt and hit_ovf cleared to 0; bit_idx=0; same bit stream replayed.

Source files
------------

// File: rtl/seq_feed_ctrl_pkg.sv
// Shared types and constants for the 101011 detector feed controller.
package seq_feed_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADED = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_FEED   = 3'd3,
    ST_STEP   = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // One auto step per second on the 50 MHz board clock.
  localparam int unsigned BOARD_PRESCALE = 50_000_000;

endpackage

// File: rtl/seq_feed_ctrl_step_prescaler.sv
// Auto-step prescaler: counts while enabled, ticks on the last count, and
// returns to zero whenever disabled so every enable starts a fresh period.
module step_prescaler
  import seq_feed_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = BOARD_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(PRESCALE);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seq_feed_ctrl.sv
// Sequences a captured switch pattern MSB-first into the 101011 detector,
// one bit per manual or prescaled step, and tallies detector hits.
module seq_feed_ctrl
  import seq_feed_ctrl_pkg::*;
#(
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned PRESCALE = BOARD_PRESCALE
) (
  input  logic              System_clk,
  input  logic              System_rst_n,
  input  logic              load,
  input  logic              start,
  input  logic              step_req,
  input  logic              auto_en,
  input  logic [WORD_W-1:0] pattern_in,
  input  logic              det_hit,
  output logic              det_bit,
  output logic              det_step,
  output logic              det_clr,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  bit_idx,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic              hit_ovf
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  state_t            state, next_state;
  logic [WORD_W-1:0] pattern;
  logic              presc_en, tick, step_ev, capture;

  assign presc_en = (state == ST_FEED) && auto_en;
  assign step_ev  = auto_en ? tick : step_req;

  step_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (System_clk),
    .rst_n (System_rst_n),
    .en    (presc_en),
    .tick  (tick)
  );

  always_ff @(posedge System_clk or negedge System_rst_n) begin
    if (!System_rst_n) state <= ST_IDLE;
    else               state <= next_state;
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          capture    = 1'b1;
          next_state = ST_LOADED;
        end
      end
      ST_LOADED, ST_DONE: begin
        // load has priority over start in both parked states
        if (load) begin
          capture    = 1'b1;
          next_state = ST_LOADED;
        end else if (start) begin
          next_state = ST_CLEAR;
        end
      end
      ST_CLEAR: next_state = ST_FEED;
      ST_FEED:  if (step_ev) next_state = ST_STEP;
      ST_STEP:  next_state = ST_CHECK;
      ST_CHECK: next_state = (bit_idx == LAST_IDX) ? ST_DONE : ST_FEED;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Status strobes are decoded from next_state so they line up with the state register.
  always_ff @(posedge System_clk or negedge System_rst_n) begin
    if (!System_rst_n) begin
      pattern  <= '0;
      det_bit  <= 1'b0;
      det_step <= 1'b0;
      det_clr  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bit_idx  <= '0;
      hit_cnt  <= '0;
      hit_ovf  <= 1'b0;
    end else begin
      if (capture) pattern <= pattern_in;
      det_clr  <= (next_state == ST_CLEAR);
      det_step <= (next_state == ST_STEP);
      busy     <= next_state inside {ST_CLEAR, ST_FEED, ST_STEP, ST_CHECK};
      done     <= (next_state == ST_DONE);

      if (state == ST_CLEAR) begin
        hit_cnt <= '0;
        hit_ovf <= 1'b0;
        bit_idx <= '0;
      end

      if (state == ST_FEED && step_ev) det_bit <= pattern[LAST_IDX - bit_idx];

      if (state == ST_CHECK) begin
        if (det_hit) begin
          if (hit_cnt == '1) hit_ovf <= 1'b1;
          else               hit_cnt <= hit_cnt + CNT_W'(1);
        end
        if (bit_idx != LAST_IDX) bit_idx <= bit_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_feed_ctrl.sv
// Bench for seq_feed_ctrl: drives randomized runs and checks the bit stream,
// hit counts and status against a pattern-level model and a 101011 detector stub.
module tb_seq_feed_ctrl;

  localparam int W  = 16;
  localparam int IW = 4;
  localparam int CW = 4;
  localparam int PS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0, start = 1'b0, step_req = 1'b0, auto_en = 1'b0;
  logic [W-1:0]  pattern_in = '0;
  logic          det_hit;
  logic          det_bit, det_step, det_clr, busy, done, hit_ovf;
  logic [IW-1:0] bit_idx;
  logic [CW-1:0] hit_cnt;

  seq_feed_ctrl #(.WORD_W(W), .IDX_W(IW), .CNT_W(CW), .PRESCALE(PS)) dut (
    .System_clk   (clk),
    .System_rst_n (rst_n),
    .load         (load),
    .start        (start),
    .step_req     (step_req),
    .auto_en      (auto_en),
    .pattern_in   (pattern_in),
    .det_hit      (det_hit),
    .det_bit      (det_bit),
    .det_step     (det_step),
    .det_clr      (det_clr),
    .busy         (busy),
    .done         (done),
    .bit_idx      (bit_idx),
    .hit_cnt      (hit_cnt),
    .hit_ovf      (hit_ovf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Detector stub: overlapping 101011 match, or forced hit on every step.
  bit         always_hit = 1'b0;
  logic [5:0] win;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_hit <= 1'b0;
      win     <= '0;
    end else if (det_clr) begin
      det_hit <= 1'b0;
      win     <= '0;
    end else if (det_step) begin
      win     <= {win[4:0], det_bit};
      det_hit <= always_hit || ({win[4:0], det_bit} == 6'b101011);
    end
  end

  bit          str_q[$];
  int unsigned step_cyc[$];
  int unsigned clr_cnt = 0;
  always @(negedge clk) begin
    if (det_step) begin
      str_q.push_back(det_bit);
      step_cyc.push_back(cyc);
    end
    if (det_clr) clr_cnt++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Number of 101011 occurrences among the first n bits of p, fed MSB-first.
  function automatic int ref_hits(input logic [W-1:0] p, input int n);
    int h = 0;
    logic [5:0] w;
    for (int i = 5; i < n; i++) begin
      for (int j = 0; j < 6; j++) w[5-j] = p[W-1-(i-5+j)];
      if (w == 6'b101011) h++;
    end
    return h;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise_tick(input bit en_noise, input bit allow_step);
    if (en_noise) begin
      load       = ($urandom_range(0, 3) == 0);
      start      = ($urandom_range(0, 3) == 0);
      pattern_in = W'($urandom);
      if (allow_step) step_req = ($urandom_range(0, 2) == 0);
    end
    tick();
    load  = 1'b0;
    start = 1'b0;
    if (allow_step) step_req = 1'b0;
  endtask

  task automatic pulse_load(input logic [W-1:0] p);
    pattern_in = p;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_det_bit"}, det_bit, 0);
    check({tag, "_det_step"}, det_step, 0);
    check({tag, "_det_clr"}, det_clr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_bit_idx"}, bit_idx, 0);
    check({tag, "_hit_cnt"}, hit_cnt, 0);
    check({tag, "_hit_ovf"}, hit_ovf, 0);
  endtask

  // Feeds nsteps bits (caller has just issued start) and checks each step.
  task automatic run_bits(input logic [W-1:0] p, input bit manual, input bit hit_all,
                          input bit noise, input int nsteps);
    int   exp_h, t;
    logic eb;
    str_q.delete();
    step_cyc.delete();
    for (int n = 1; n <= nsteps; n++) begin
      if (manual) begin
        repeat ($urandom_range(1, 3)) noise_tick(noise, 1'b0);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
      end
      t = 0;
      while (str_q.size() < n && t < 40) begin
        noise_tick(noise, !manual);
        t++;
      end
      check("step_seen", str_q.size(), n);
      if (str_q.size() < n) return;
      tick();
      exp_h = hit_all ? n : ref_hits(p, n);
      eb    = p[W-1-(n-1)];
      check("det_bit", str_q[n-1], eb);
      check("hit_cnt", hit_cnt, (exp_h > 15) ? 15 : exp_h);
      check("hit_ovf", hit_ovf, (exp_h > 15) ? 1 : 0);
      check("bit_idx", bit_idx, (n < W) ? n : W - 1);
    end
    if (nsteps == W) begin
      check("done", done, 1);
      check("busy_end", busy, 0);
      check("step_total", str_q.size(), W);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned  clr0;
  logic [W-1:0] p;

  initial begin
    #12;
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Manual run of the reference pattern with ignored load/start noise.
    clr0 = clr_cnt;
    pulse_load(16'hAD60);
    check("loaded_busy", busy, 0);
    check("loaded_done", done, 0);
    pulse_start();
    run_bits(16'hAD60, 1'b1, 1'b0, 1'b1, W);
    check("manual_clr_pulses", clr_cnt - clr0, 1);
    check("manual_final_hits", hit_cnt, 2);

    // Auto mode, every step hits: saturation and overflow, 6-cycle cadence.
    always_hit = 1'b1;
    auto_en = 1'b1;
    pulse_load(16'hFFFF);
    pulse_start();
    run_bits(16'hFFFF, 1'b0, 1'b1, 1'b1, W);
    for (int i = 1; i < step_cyc.size(); i++)
      check("auto_step_period", step_cyc[i] - step_cyc[i-1], 6);

    // Rerun from DONE clears the counters and replays the same pattern.
    always_hit = 1'b0;
    auto_en = 1'b0;
    clr0 = clr_cnt;
    pulse_start();
    check("rerun_det_clr", det_clr, 1);
    tick();
    check("rerun_hit_cnt", hit_cnt, 0);
    check("rerun_hit_ovf", hit_ovf, 0);
    check("rerun_bit_idx", bit_idx, 0);
    check("rerun_busy", busy, 1);
    run_bits(16'hFFFF, 1'b1, 1'b0, 1'b0, W);
    check("rerun_clr_pulses", clr_cnt - clr0, 1);

    // Simultaneous load+start in DONE, then in LOADED: load wins each time.
    clr0 = clr_cnt;
    pattern_in = W'($urandom);
    load = 1'b1; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    tick();
    check("ls_done_done", done, 0);
    check("ls_done_busy", busy, 0);
    p = W'($urandom);
    pattern_in = p;
    load = 1'b1; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    pattern_in = ~p;
    tick();
    check("ls_loaded_busy", busy, 0);
    check("ls_clr_pulses", clr_cnt - clr0, 0);
    pulse_start();
    run_bits(p, 1'b1, 1'b0, 1'b1, W);

    // Random patterns in auto mode against the detector model.
    for (int r = 0; r < 2; r++) begin
      p = W'($urandom);
      auto_en = 1'b1;
      pulse_load(p);
      pulse_start();
      run_bits(p, 1'b0, 1'b0, 1'b1, W);
    end

    // Reset in the middle of a manual run at bit_idx 7.
    auto_en = 1'b0;
    p = W'($urandom);
    pulse_load(p);
    pulse_start();
    run_bits(p, 1'b1, 1'b0, 1'b0, 7);
    #2 rst_n = 1'b0;
    #1 check_zero("midrun_reset");
    #2 rst_n = 1'b1;
    tick();
    clr0 = clr_cnt;
    pulse_start();
    tick();
    check("post_reset_busy", busy, 0);
    check("post_reset_done", done, 0);
    check("post_reset_clr", clr_cnt - clr0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
